ctrl_sequencer: RTL and testbench

Multi-cycle control unit for the 8-bit accumulator processor. It sequences fetch, decode, execute and writeback over the instruction memory, register file and ALU/accumulator datapath, and drives every read, write and start strobe those blocks receive. It also handles jumps, conditional branches, halt and a stuck-ALU watchdog. It sits at the top of `Processor`, between `inst_mem`, `reg_file` and the ALU.

---
 rtl/proc_pkg.sv | 29 ++
 rtl/exec_watchdog.sv | 32 +++
 rtl/ctrl_sequencer.sv | 124 ++++++++++++
 tb/tb_ctrl_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared constants for the 8-bit accumulator processor: instruction fields,
// opcode map and the control sequencer state encoding.
package proc_pkg;

  localparam int INSTR_W = 8;
  localparam int OPC_W   = 4;
  localparam int OPND_W  = 4;

  localparam logic [OPC_W-1:0] OP_JMP = 4'h8;
  localparam logic [OPC_W-1:0] OP_BZ  = 4'h9;
  localparam logic [OPC_W-1:0] OP_ST  = 4'hA;
  localparam logic [OPC_W-1:0] OP_LD  = 4'hB;
  localparam logic [OPC_W-1:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    WB     = 3'd3,
    HALT   = 3'd4,
    ERR    = 3'd5
  } state_e;

  // Opcodes 0x0-0x7 are ALU operations.
  function automatic logic is_alu_op(input logic [OPC_W-1:0] opc);
    return ~opc[OPC_W-1];
  endfunction

endpackage

// File: rtl/exec_watchdog.sv
// Counts EXEC cycles spent waiting on the ALU; flags the TIMEOUT-th such cycle.
module exec_watchdog #(
  parameter int TIMEOUT = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,   // one EXEC cycle without alu_done is being counted
  input  logic clear_i,
  output logic expire_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)
      cnt_d = '0;
    else if (start_i && (cnt_q != CNT_W'(TIMEOUT)))
      cnt_d = cnt_q + CNT_W'(1);
  end

  // Combinational so the sequencer can divert to ERR on this very cycle.
  assign expire_o = start_i && (cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/WB control unit for the accumulator processor,
// with jumps, branch-on-zero, halt and an ALU watchdog.
module ctrl_sequencer
  import proc_pkg::*;
#(
  parameter int PC_W    = 4,
  parameter int TIMEOUT = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [INSTR_W-1:0]  instr_i,
  input  logic                hold_i,
  input  logic                alu_done_i,
  input  logic                acc_zero_i,
  output logic [PC_W-1:0]     pc_o,
  output logic [OPND_W-1:0]   rf_addr_o,
  output logic                rf_rd_en_o,
  output logic                rf_we_o,
  output logic [2:0]          alu_op_o,
  output logic                alu_start_o,
  output logic                acc_we_o,
  output logic                acc_sel_o,
  output logic                halted_o,
  output logic                err_o
);

  state_e              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [INSTR_W-1:0]  ir_q, ir_d;
  logic                started_q, started_d;

  logic [OPC_W-1:0]    opc;
  logic [OPND_W-1:0]   opnd;
  logic                is_alu;
  logic                wd_tick, wd_clear, wd_expire;
  logic [PC_W-1:0]     pc_inc;

  assign opc    = ir_q[INSTR_W-1 -: OPC_W];
  assign opnd   = ir_q[OPND_W-1:0];
  assign is_alu = is_alu_op(opc);
  assign pc_inc = pc_q + PC_W'(1);

  assign wd_tick  = (state_q == EXEC) && is_alu && !alu_done_i;
  assign wd_clear = (state_q != EXEC);

  exec_watchdog #(.TIMEOUT(TIMEOUT)) u_exec_watchdog (
    .clk      (clk),
    .rst      (rst),
    .start_i  (wd_tick),
    .clear_i  (wd_clear),
    .expire_o (wd_expire)
  );

  // Marks EXEC cycles after the first, so the ALU start is a single pulse.
  assign started_d = (state_q == EXEC);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    rf_rd_en_o  = 1'b0;
    rf_we_o     = 1'b0;
    alu_start_o = 1'b0;
    acc_we_o    = 1'b0;
    acc_sel_o   = 1'b0;
    case (state_q)
      FETCH: begin
        if (!hold_i) begin
          ir_d    = instr_i;
          state_d = DECODE;
        end
      end
      DECODE: begin
        rf_rd_en_o = is_alu || (opc == OP_LD);
        state_d    = (opc == OP_HLT) ? HALT : EXEC;
      end
      EXEC: begin
        if (is_alu) begin
          alu_start_o = !started_q;
          if (alu_done_i)     state_d = WB;
          else if (wd_expire) state_d = ERR;
        end else begin
          state_d = WB;
        end
      end
      WB: begin
        acc_we_o  = is_alu || (opc == OP_LD);
        acc_sel_o = (opc == OP_LD);
        rf_we_o   = (opc == OP_ST);
        if (opc == OP_JMP)
          pc_d = PC_W'(opnd);
        else if (opc == OP_BZ)
          pc_d = acc_zero_i ? PC_W'(opnd) : pc_inc;
        else
          pc_d = pc_inc;
        state_d = FETCH;
      end
      HALT:    state_d = HALT;
      ERR:     state_d = ERR;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH;
      pc_q      <= '0;
      ir_q      <= '0;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      started_q <= started_d;
    end
  end

  assign pc_o      = pc_q;
  assign rf_addr_o = opnd;
  assign alu_op_o  = opc[2:0];
  assign halted_o  = (state_q == HALT);
  assign err_o     = (state_q == ERR);

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed bench for ctrl_sequencer: per-cycle expected-output tables plus
// hand-written sequences for wrap, halt, watchdog and mid-EXEC reset.
module tb_ctrl_sequencer;

  logic       clk;
  logic       rst;
  logic [7:0] instr_i;
  logic       hold_i;
  logic       alu_done_i;
  logic       acc_zero_i;
  logic [3:0] pc_o;
  logic [3:0] rf_addr_o;
  logic       rf_rd_en_o;
  logic       rf_we_o;
  logic [2:0] alu_op_o;
  logic       alu_start_o;
  logic       acc_we_o;
  logic       acc_sel_o;
  logic       halted_o;
  logic       err_o;

  ctrl_sequencer #(.PC_W(4), .TIMEOUT(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_i     (instr_i),
    .hold_i      (hold_i),
    .alu_done_i  (alu_done_i),
    .acc_zero_i  (acc_zero_i),
    .pc_o        (pc_o),
    .rf_addr_o   (rf_addr_o),
    .rf_rd_en_o  (rf_rd_en_o),
    .rf_we_o     (rf_we_o),
    .alu_op_o    (alu_op_o),
    .alu_start_o (alu_start_o),
    .acc_we_o    (acc_we_o),
    .acc_sel_o   (acc_sel_o),
    .halted_o    (halted_o),
    .err_o       (err_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Instruction memory model
  logic [7:0] mem [0:15];
  assign instr_i = mem[pc_o];

  // ALU done model: done_k==0 ties done to start, else done k cycles after start
  int   done_k;
  int   dn_since;
  logic dn_active;
  assign alu_done_i = (done_k == 0) ? alu_start_o : (dn_active && (dn_since == done_k));

  always @(posedge clk) begin
    if (rst) begin
      dn_active <= 1'b0;
      dn_since  <= 0;
    end else if (alu_start_o && !alu_done_i) begin
      dn_active <= 1'b1;
      dn_since  <= 1;
    end else if (alu_done_i) begin
      dn_active <= 1'b0;
    end else if (dn_active) begin
      dn_since  <= dn_since + 1;
    end
  end

  // Observed vector: {pc, rf_addr, alu_op, rd, we, start, acc_we, sel, halted, err}
  localparam logic [6:0] F_RD  = 7'b1000000;
  localparam logic [6:0] F_WE  = 7'b0100000;
  localparam logic [6:0] F_ST  = 7'b0010000;
  localparam logic [6:0] F_AW  = 7'b0001000;
  localparam logic [6:0] F_SEL = 7'b0000100;
  localparam logic [6:0] F_H   = 7'b0000010;
  localparam logic [6:0] F_E   = 7'b0000001;

  function automatic logic [17:0] mk(input logic [3:0] pc, input logic [3:0] ad,
                                     input logic [2:0] op, input logic [6:0] fl);
    return {pc, ad, op, fl};
  endfunction

  function automatic logic [17:0] obs();
    return {pc_o, rf_addr_o, alu_op_o, rf_rd_en_o, rf_we_o, alu_start_o,
            acc_we_o, acc_sel_o, halted_o, err_o};
  endfunction

  typedef struct {
    logic        hold;
    logic        az;
    logic [17:0] exp;
  } vec_t;

  vec_t vt [0:63];
  int   nv;
  int   errors;
  int   checks;

  task automatic check(input string name, input int cyc, input logic [17:0] got,
                       input logic [17:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got=%05h expected=%05h", name, cyc, got, exp);
    end
  endtask

  task automatic add(input logic h, input logic az, input logic [17:0] exp);
    vt[nv] = '{hold: h, az: az, exp: exp};
    nv++;
  endtask

  task automatic load_nops();
    for (int a = 0; a < 16; a++) mem[a] = 8'hC0;
  endtask

  // Leaves the bench #1 into cycle 1 (first FETCH after reset).
  task automatic do_reset();
    rst        = 1'b1;
    hold_i     = 1'b0;
    acc_zero_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic run_table(input string name);
    for (int i = 0; i < nv; i++) begin
      if (i != 0) begin
        @(posedge clk);
        #1;
      end
      hold_i     = vt[i].hold;
      acc_zero_i = vt[i].az;
      @(negedge clk);
      check(name, i + 1, obs(), vt[i].exp);
    end
    nv = 0;
    hold_i     = 1'b0;
    acc_zero_i = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    nv     = 0;
    done_k = 0;
    rst    = 1'b1;
    hold_i = 1'b0;
    acc_zero_i = 1'b0;
    load_nops();

    // Reset state while rst is held
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_state", 0, obs(), 18'h0);

    // ALU op, done tied to start
    load_nops(); mem[0] = 8'h01; done_k = 0;
    do_reset();
    add(0, 0, mk(4'd0, 4'd0, 3'd0, 7'd0));
    add(0, 0, mk(4'd0, 4'd1, 3'd0, F_RD));
    add(0, 0, mk(4'd0, 4'd1, 3'd0, F_ST));
    add(0, 0, mk(4'd0, 4'd1, 3'd0, F_AW));
    add(0, 0, mk(4'd1, 4'd1, 3'd0, 7'd0));
    run_table("alu_tied");

    // ALU op, done 5 cycles after start
    load_nops(); mem[0] = 8'h23; done_k = 5;
    do_reset();
    add(0, 0, mk(4'd0, 4'd0, 3'd0, 7'd0));
    add(0, 0, mk(4'd0, 4'd3, 3'd2, F_RD));
    add(0, 0, mk(4'd0, 4'd3, 3'd2, F_ST));
    for (int i = 0; i < 5; i++) add(0, 0, mk(4'd0, 4'd3, 3'd2, 7'd0));
    add(0, 0, mk(4'd0, 4'd3, 3'd2, F_AW));
    add(0, 0, mk(4'd1, 4'd3, 3'd2, 7'd0));
    run_table("alu_delay5");

    // JMP
    load_nops(); mem[0] = 8'h82; done_k = 0;
    do_reset();
    add(0, 0, mk(4'd0, 4'd0, 3'd0, 7'd0));
    for (int i = 0; i < 3; i++) add(0, 0, mk(4'd0, 4'd2, 3'd0, 7'd0));
    add(0, 0, mk(4'd2, 4'd2, 3'd0, 7'd0));
    run_table("jmp");

    // BZ not taken then taken
    for (int z = 0; z < 2; z++) begin
      load_nops(); mem[0] = 8'h95;
      do_reset();
      add(z[0], z[0] ? 1'b1 : 1'b0, mk(4'd0, 4'd0, 3'd0, 7'd0));
      add(0, z[0], mk(4'd0, 4'd5, 3'd1, 7'd0));
      add(0, z[0], mk(4'd0, 4'd5, 3'd1, 7'd0));
      add(0, z[0], mk(4'd0, 4'd5, 3'd1, 7'd0));
      add(0, z[0], mk(z[0] ? 4'd5 : 4'd1, 4'd5, 3'd1, 7'd0));
      vt[0].hold = 1'b0;
      run_table(z[0] ? "bz_taken" : "bz_not_taken");
    end

    // ST then LD
    load_nops(); mem[0] = 8'hA7; mem[1] = 8'hB7;
    do_reset();
    add(0, 0, mk(4'd0, 4'd0, 3'd0, 7'd0));
    add(0, 0, mk(4'd0, 4'd7, 3'd2, 7'd0));
    add(0, 0, mk(4'd0, 4'd7, 3'd2, 7'd0));
    add(0, 0, mk(4'd0, 4'd7, 3'd2, F_WE));
    add(0, 0, mk(4'd1, 4'd7, 3'd2, 7'd0));
    add(0, 0, mk(4'd1, 4'd7, 3'd3, F_RD));
    add(0, 0, mk(4'd1, 4'd7, 3'd3, 7'd0));
    add(0, 0, mk(4'd1, 4'd7, 3'd3, F_AW | F_SEL));
    add(0, 0, mk(4'd2, 4'd7, 3'd3, 7'd0));
    run_table("st_ld");

    // hold for 3 FETCH cycles; hold mid-instruction is ignored
    load_nops(); mem[0] = 8'h01; done_k = 0;
    do_reset();
    for (int i = 0; i < 3; i++) add(1, 0, mk(4'd0, 4'd0, 3'd0, 7'd0));
    add(0, 0, mk(4'd0, 4'd0, 3'd0, 7'd0));
    add(1, 0, mk(4'd0, 4'd1, 3'd0, F_RD));
    add(1, 0, mk(4'd0, 4'd1, 3'd0, F_ST));
    add(1, 0, mk(4'd0, 4'd1, 3'd0, F_AW));
    add(0, 0, mk(4'd1, 4'd1, 3'd0, 7'd0));
    run_table("hold");

    // Watchdog: done never arrives
    load_nops(); mem[0] = 8'h01; done_k = 1000;
    do_reset();
    add(0, 0, mk(4'd0, 4'd0, 3'd0, 7'd0));
    add(0, 0, mk(4'd0, 4'd1, 3'd0, F_RD));
    add(0, 0, mk(4'd0, 4'd1, 3'd0, F_ST));
    for (int i = 0; i < 31; i++) add(0, 0, mk(4'd0, 4'd1, 3'd0, 7'd0));
    add(0, 0, mk(4'd0, 4'd1, 3'd0, F_E));
    add(0, 0, mk(4'd0, 4'd1, 3'd0, F_E));
    run_table("watchdog");
    do_reset();
    @(negedge clk);
    check("err_cleared_by_rst", 0, obs(), 18'h0);

    // Done on the 32nd EXEC cycle wins over the timeout
    load_nops(); mem[0] = 8'h01; done_k = 31;
    do_reset();
    add(0, 0, mk(4'd0, 4'd0, 3'd0, 7'd0));
    add(0, 0, mk(4'd0, 4'd1, 3'd0, F_RD));
    add(0, 0, mk(4'd0, 4'd1, 3'd0, F_ST));
    for (int i = 0; i < 31; i++) add(0, 0, mk(4'd0, 4'd1, 3'd0, 7'd0));
    add(0, 0, mk(4'd0, 4'd1, 3'd0, F_AW));
    add(0, 0, mk(4'd1, 4'd1, 3'd0, 7'd0));
    run_table("done_vs_timeout");

    // PC wrap through 15 back to 0
    load_nops(); done_k = 0;
    do_reset();
    for (int i = 0; i <= 16; i++) begin
      logic [3:0] ep;
      ep = 4'(i);
      @(negedge clk);
      check("pc_wrap", 4 * i + 1, {14'd0, pc_o}, {14'd0, ep});
      repeat (4) @(posedge clk);
      #1;
    end

    // NOPs up to 14, HLT at 15
    load_nops(); mem[15] = 8'hFF;
    do_reset();
    for (int i = 0; i <= 15; i++) begin
      logic [3:0] ep;
      ep = 4'(i);
      @(negedge clk);
      check("halt_pc", 4 * i + 1, {14'd0, pc_o}, {14'd0, ep});
      if (i != 15) begin
        repeat (4) @(posedge clk);
        #1;
      end
    end
    next_cycle();
    @(negedge clk);
    check("halt_decode", 62, obs(), mk(4'd15, 4'd15, 3'd7, 7'd0));
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      @(negedge clk);
      check("halted", 63 + i, obs(), mk(4'd15, 4'd15, 3'd7, F_H));
    end
    do_reset();
    @(negedge clk);
    check("halt_cleared_by_rst", 0, obs(), 18'h0);

    // Reset asserted mid-EXEC
    load_nops(); mem[0] = 8'h01; done_k = 1000;
    do_reset();
    repeat (4) next_cycle();
    @(negedge clk);
    check("mid_exec", 5, obs(), mk(4'd0, 4'd1, 3'd0, 7'd0));
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_exec", 1, obs(), 18'h0);
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("restart_after_rst", 3, obs(), mk(4'd0, 4'd1, 3'd0, F_ST));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
